// File: rtl/diag_mem_engine.sv
// diag_mem_engine: diagnostics controller sitting between an SPI byte slave
// and the shadow RAM port. It halts/resumes the CPU, serves config and status
// reads, and performs ranged RAM reads/writes protected by a CRC-32.
// All commands and data arrive one byte at a time on rx_dv/rx_byte.
//
// Ports:
//   fpga_clk, fpga_reset   clock and synchronous active-high reset
//   rx_dv, rx_byte         received byte strobe and data from the SPI slave
//   spi_cs_n               SPI select (synchronised); a rise aborts transfers
//   tx_dv, tx_byte         reply byte load strobe and data to the SPI slave
//   halt                   CPU halt request
//   mem_addr, mem_wdata    shadow RAM address and write data
//   mem_rdata              shadow RAM read data (MEM_LATENCY cycles behind)
//   mem_cs, mem_we         RAM port ownership and write strobe
//   config_in              board configuration value (zero-extended on reply)
//   status                 status of the last ranged command
module diag_mem_engine #(
  parameter int ADDR_WIDTH   = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int CONFIG_WIDTH = 8
) (
  input  logic                    fpga_clk,
  input  logic                    fpga_reset,
  input  logic                    rx_dv,
  input  logic [7:0]              rx_byte,
  input  logic                    spi_cs_n,
  output logic                    tx_dv,
  output logic [7:0]              tx_byte,
  output logic                    halt,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata,
  output logic                    mem_cs,
  output logic                    mem_we,
  input  logic [CONFIG_WIDTH-1:0] config_in,
  output logic [7:0]              status
);

  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int HDR_BYTES  = 2 * ADDR_BYTES;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   REM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [7:0] CMD_HALT   = 8'hAA;
  localparam logic [7:0] CMD_RESUME = 8'h55;
  localparam logic [7:0] CMD_READ   = 8'h66;
  localparam logic [7:0] CMD_WRITE  = 8'h99;
  localparam logic [7:0] CMD_CONFIG = 8'h77;
  localparam logic [7:0] CMD_STATUS = 8'h33;

  typedef enum logic [2:0] {
    RUNNING, HALTED, HDR, RD_FETCH, RD_WAIT, CRC_TX, WR_DATA, WR_CRC
  } stateT;

  stateT                 state_q, state_d;
  logic                  halt_q, halt_d;
  logic                  memCs_q, memCs_d;
  logic                  memWe_q, memWe_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [7:0]            memWdata_q, memWdata_d;
  logic                  txDv_q, txDv_d;
  logic [7:0]            txByte_q, txByte_d;
  logic [7:0]            status_q, status_d;
  logic [31:0]           crc_q, crc_d;
  logic [31:0]           rxCrc_q, rxCrc_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [7:0]            hdrCnt_q, hdrCnt_d;
  logic [2:0]            latCnt_q, latCnt_d;
  logic [2:0]            byteIdx_q, byteIdx_d;
  logic                  isWrite_q, isWrite_d;
  logic                  csPrev_q;

  logic                  csRise;
  logic [7:0]            cfgByte;
  logic [31:0]           crcRd, crcWr, crcOut, rxCrcFull;
  logic [ADDR_WIDTH+7:0] addrShift, lenShift;

  // Bitwise reflected CRC-32 byte update; unrolls into one cycle of XOR logic.
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Configuration value widened to a full reply byte.
  always_comb begin
    cfgByte = '0;
    cfgByte[CONFIG_WIDTH-1:0] = config_in;
  end

  assign csRise    = spi_cs_n & ~csPrev_q;
  assign crcRd     = crcByte(crc_q, mem_rdata);
  assign crcWr     = crcByte(crc_q, rx_byte);
  assign crcOut    = ~crc_q;
  assign rxCrcFull = {rxCrc_q[23:0], rx_byte};
  assign addrShift = {memAddr_q, rx_byte};
  assign lenShift  = {remaining_q[ADDR_WIDTH-1:0], rx_byte};

  // Next-state and output logic. A select rise during any ranged transfer
  // takes priority over a byte received in the same cycle.
  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    memCs_d     = memCs_q;
    memWe_d     = 1'b0;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    txDv_d      = 1'b0;
    txByte_d    = txByte_q;
    status_d    = status_q;
    crc_d       = crc_q;
    rxCrc_d     = rxCrc_q;
    remaining_d = remaining_q;
    hdrCnt_d    = hdrCnt_q;
    latCnt_d    = latCnt_q;
    byteIdx_d   = byteIdx_q;
    isWrite_d   = isWrite_q;

    // The write address advances only after its write strobe has been seen.
    if (memWe_q) memAddr_d = memAddr_q + ADDR_ONE;

    if (csRise && state_q != RUNNING && state_q != HALTED) begin
      memCs_d  = 1'b0;
      memWe_d  = 1'b0;
      status_d = 8'hA5;
      state_d  = HALTED;
    end else begin
      case (state_q)
        RUNNING: if (rx_dv) begin
          case (rx_byte)
            CMD_HALT:   begin halt_d = 1'b1; state_d = HALTED; end
            CMD_CONFIG: begin txDv_d = 1'b1; txByte_d = cfgByte; end
            CMD_STATUS: begin txDv_d = 1'b1; txByte_d = status_q; end
            CMD_READ, CMD_WRITE: begin
              status_d = 8'hEE;
              txDv_d   = 1'b1;
              txByte_d = 8'hEE;
            end
            default: ;
          endcase
        end
        HALTED: if (rx_dv) begin
          case (rx_byte)
            CMD_RESUME: begin halt_d = 1'b0; state_d = RUNNING; end
            CMD_CONFIG: begin txDv_d = 1'b1; txByte_d = cfgByte; end
            CMD_STATUS: begin txDv_d = 1'b1; txByte_d = status_q; end
            CMD_READ, CMD_WRITE: begin
              hdrCnt_d  = '0;
              isWrite_d = (rx_byte == CMD_WRITE);
              state_d   = HDR;
            end
            default: ;
          endcase
        end
        // Address bytes first, then length bytes; a zero length means the
        // full address space.
        HDR: if (rx_dv) begin
          if (hdrCnt_q < 8'(ADDR_BYTES)) memAddr_d = addrShift[ADDR_WIDTH-1:0];
          else remaining_d = {1'b0, lenShift[ADDR_WIDTH-1:0]};
          hdrCnt_d = hdrCnt_q + 8'd1;
          if (hdrCnt_q == 8'(HDR_BYTES - 1)) begin
            if (lenShift[ADDR_WIDTH-1:0] == '0) remaining_d = REM_FULL;
            memCs_d  = 1'b1;
            crc_d    = 32'hFFFFFFFF;
            latCnt_d = '0;
            state_d  = isWrite_q ? WR_DATA : RD_FETCH;
          end
        end
        RD_FETCH: begin
          if (latCnt_q == 3'(MEM_LATENCY)) begin
            txDv_d   = 1'b1;
            txByte_d = mem_rdata;
            crc_d    = crcRd;
            state_d  = RD_WAIT;
          end else begin
            latCnt_d = latCnt_q + 3'd1;
          end
        end
        // The host's filler byte shifts out the loaded data; the last one
        // also queues the first CRC byte.
        RD_WAIT: if (rx_dv) begin
          memAddr_d   = memAddr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q != REM_ONE) begin
            latCnt_d = '0;
            state_d  = RD_FETCH;
          end else begin
            txDv_d    = 1'b1;
            txByte_d  = crcOut[31:24];
            byteIdx_d = 3'd1;
            state_d   = CRC_TX;
          end
        end
        CRC_TX: if (rx_dv) begin
          txDv_d = 1'b1;
          if (byteIdx_q == 3'd4) begin
            txByte_d = 8'h00;
            memCs_d  = 1'b0;
            status_d = 8'h00;
            state_d  = HALTED;
          end else begin
            case (byteIdx_q)
              3'd1:    txByte_d = crcOut[23:16];
              3'd2:    txByte_d = crcOut[15:8];
              default: txByte_d = crcOut[7:0];
            endcase
            byteIdx_d = byteIdx_q + 3'd1;
          end
        end
        WR_DATA: if (rx_dv) begin
          memWdata_d  = rx_byte;
          memWe_d     = 1'b1;
          crc_d       = crcWr;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            byteIdx_d = '0;
            state_d   = WR_CRC;
          end
        end
        WR_CRC: if (rx_dv) begin
          rxCrc_d   = rxCrcFull;
          byteIdx_d = byteIdx_q + 3'd1;
          if (byteIdx_q == 3'd3) begin
            status_d = (rxCrcFull == crcOut) ? 8'h00 : 8'hC3;
            txDv_d   = 1'b1;
            txByte_d = (rxCrcFull == crcOut) ? 8'h00 : 8'hC3;
            memCs_d  = 1'b0;
            state_d  = HALTED;
          end
        end
        default: state_d = RUNNING;
      endcase
    end
  end

  // State register; reset drops any transfer in flight without writing.
  always_ff @(posedge fpga_clk) begin
    if (fpga_reset) begin
      state_q     <= RUNNING;
      halt_q      <= 1'b0;
      memCs_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      txDv_q      <= 1'b0;
      txByte_q    <= '0;
      status_q    <= '0;
      crc_q       <= '0;
      rxCrc_q     <= '0;
      remaining_q <= '0;
      hdrCnt_q    <= '0;
      latCnt_q    <= '0;
      byteIdx_q   <= '0;
      isWrite_q   <= 1'b0;
      csPrev_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      memCs_q     <= memCs_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      txDv_q      <= txDv_d;
      txByte_q    <= txByte_d;
      status_q    <= status_d;
      crc_q       <= crc_d;
      rxCrc_q     <= rxCrc_d;
      remaining_q <= remaining_d;
      hdrCnt_q    <= hdrCnt_d;
      latCnt_q    <= latCnt_d;
      byteIdx_q   <= byteIdx_d;
      isWrite_q   <= isWrite_d;
      csPrev_q    <= spi_cs_n;
    end
  end

  assign tx_dv     = txDv_q;
  assign tx_byte   = txByte_q;
  assign halt      = halt_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_cs    = memCs_q;
  assign mem_we    = memWe_q;
  assign status    = status_q;

endmodule

// File: tb/tb_diag_mem_engine.sv
// tb_diag_mem_engine: directed bench for diag_mem_engine with a one-cycle
// synchronous RAM model and a host that sends one byte every few cycles.
module tb_diag_mem_engine;

  localparam int LAT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        rxDv;
  logic [7:0]  rxByte;
  logic        spiCsN;
  logic        txDv;
  logic [7:0]  txByte;
  logic        halt;
  logic [15:0] memAddr;
  logic [7:0]  memWdata;
  logic [7:0]  memRdata;
  logic        memCs;
  logic        memWe;
  logic [7:0]  configIn;
  logic [7:0]  status;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ram [0:65535];
  int          txCount = 0;
  logic [7:0]  lastTx = 8'h00;
  int          weCount = 0;
  logic [15:0] weAddr [$];
  int          weBad = 0;
  logic        csSeen = 1'b0;
  int          cycle = 0;
  int          lastRxCycle = 0;
  int          maxDelay = 0;
  logic [7:0]  good [0:8];

  diag_mem_engine #(.ADDR_WIDTH(16), .MEM_LATENCY(LAT), .CONFIG_WIDTH(8)) dut (
    .fpga_clk(clock), .fpga_reset(reset), .rx_dv(rxDv), .rx_byte(rxByte),
    .spi_cs_n(spiCsN), .tx_dv(txDv), .tx_byte(txByte), .halt(halt),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata),
    .mem_cs(memCs), .mem_we(memWe), .config_in(configIn), .status(status)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Synchronous RAM: one cycle from address to read data.
  always @(posedge clock) begin
    if (memWe) ram[memAddr] <= memWdata;
    memRdata <= ram[memAddr];
  end

  // Host-side monitor sampled on the falling edge.
  always @(negedge clock) begin
    cycle++;
    if (rxDv) lastRxCycle = cycle;
    if (txDv) begin
      txCount++;
      lastTx = txByte;
      if (cycle - lastRxCycle > maxDelay) maxDelay = cycle - lastRxCycle;
    end
    if (memWe) begin
      weCount++;
      weAddr.push_back(memAddr);
      if (!memCs) weBad++;
    end
    if (memCs) csSeen = 1'b1;
  end

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One SPI byte exchange followed by idle time for the reply.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    rxDv = 1'b1;
    rxByte = b;
    @(negedge clock);
    rxDv = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic sendHeader(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] len);
    applyStimulus(cmd);
    applyStimulus(addr[15:8]);
    applyStimulus(addr[7:0]);
    applyStimulus(len[15:8]);
    applyStimulus(len[7:0]);
  endtask

  initial begin
    int base;
    int txBase;
    logic [7:0] expRd [0:13];

    for (int i = 0; i < 9; i++) good[i] = 8'h31 + 8'(i);
    reset = 1'b1; rxDv = 1'b0; rxByte = 8'h00; spiCsN = 1'b0; configIn = 8'h05;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    checkOutput("rst_halt", {31'd0, halt}, 32'd0);
    checkOutput("rst_mem_cs", {31'd0, memCs}, 32'd0);
    checkOutput("rst_tx_dv", {31'd0, txDv}, 32'd0);
    checkOutput("rst_tx_byte", {24'd0, txByte}, 32'h00);
    checkOutput("rst_status", {24'd0, status}, 32'h00);
    checkOutput("rst_mem_addr", {16'd0, memAddr}, 32'h0);

    // Config read while running.
    txBase = txCount;
    applyStimulus(8'h77);
    checkOutput("cfg_pulses", txCount - txBase, 32'd1);
    checkOutput("cfg_byte", {24'd0, lastTx}, 32'h05);
    checkOutput("cfg_halt", {31'd0, halt}, 32'd0);

    // Ranged command refused while running.
    csSeen = 1'b0;
    applyStimulus(8'h66);
    checkOutput("run_rd_status", {24'd0, status}, 32'hEE);
    checkOutput("run_rd_tx", {24'd0, lastTx}, 32'hEE);
    checkOutput("run_rd_cs", {31'd0, csSeen}, 32'd0);

    // Halt, then a verified write of "123456789".
    txBase = txCount;
    applyStimulus(8'hAA);
    checkOutput("halt_set", {31'd0, halt}, 32'd1);
    checkOutput("halt_no_tx", txCount - txBase, 32'd0);
    base = weCount;
    sendHeader(8'h99, 16'h1000, 16'h0009);
    for (int i = 0; i < 9; i++) applyStimulus(good[i]);
    applyStimulus(8'hCB); applyStimulus(8'hF4); applyStimulus(8'h39); applyStimulus(8'h26);
    checkOutput("wr_we_count", weCount - base, 32'd9);
    for (int i = 0; i < 9; i++) begin
      checkOutput("wr_addr", {16'd0, weAddr[base + i]}, 32'h1000 + i);
      checkOutput("wr_ram", {24'd0, ram[16'h1000 + 16'(i)]}, {24'd0, good[i]});
    end
    checkOutput("wr_status", {24'd0, status}, 32'h00);
    checkOutput("wr_tx", {24'd0, lastTx}, 32'h00);
    checkOutput("wr_cs_off", {31'd0, memCs}, 32'd0);
    checkOutput("wr_halt", {31'd0, halt}, 32'd1);

    // Read the range back: data, CRC, then the closing zero.
    for (int i = 0; i < 9; i++) expRd[i] = good[i];
    expRd[9] = 8'hCB; expRd[10] = 8'hF4; expRd[11] = 8'h39; expRd[12] = 8'h26; expRd[13] = 8'h00;
    txBase = txCount;
    sendHeader(8'h66, 16'h1000, 16'h0009);
    checkOutput("rd_byte", {24'd0, lastTx}, {24'd0, expRd[0]});
    for (int i = 1; i < 14; i++) begin
      applyStimulus(8'h00);
      checkOutput("rd_byte", {24'd0, lastTx}, {24'd0, expRd[i]});
    end
    checkOutput("rd_pulses", txCount - txBase, 32'd14);
    checkOutput("rd_status", {24'd0, status}, 32'h00);
    checkOutput("rd_cs_off", {31'd0, memCs}, 32'd0);

    // Same data with a corrupted CRC to another address: written anyway.
    base = weCount;
    sendHeader(8'h99, 16'h2000, 16'h0009);
    for (int i = 0; i < 9; i++) applyStimulus(good[i]);
    applyStimulus(8'hCB); applyStimulus(8'hF4); applyStimulus(8'h39); applyStimulus(8'h27);
    checkOutput("bad_we_count", weCount - base, 32'd9);
    checkOutput("bad_ram_first", {24'd0, ram[16'h2000]}, 32'h31);
    checkOutput("bad_ram_last", {24'd0, ram[16'h2008]}, 32'h39);
    checkOutput("bad_status", {24'd0, status}, 32'hC3);
    checkOutput("bad_tx", {24'd0, lastTx}, 32'hC3);

    // Address wrap: two bytes starting at the top of memory.
    base = weCount;
    sendHeader(8'h99, 16'hFFFF, 16'h0002);
    applyStimulus(8'hA1); applyStimulus(8'hB2);
    for (int i = 0; i < 4; i++) applyStimulus(8'h00);
    checkOutput("wrap_we_count", weCount - base, 32'd2);
    checkOutput("wrap_addr0", {16'd0, weAddr[base]}, 32'hFFFF);
    checkOutput("wrap_addr1", {16'd0, weAddr[base + 1]}, 32'h0000);
    sendHeader(8'h66, 16'hFFFF, 16'h0002);
    checkOutput("wrap_rd0", {24'd0, lastTx}, 32'hA1);
    applyStimulus(8'h00);
    checkOutput("wrap_rd1", {24'd0, lastTx}, 32'hB2);
    for (int i = 0; i < 5; i++) applyStimulus(8'h00);
    checkOutput("wrap_end_tx", {24'd0, lastTx}, 32'h00);
    checkOutput("wrap_status", {24'd0, status}, 32'h00);

    // Abort mid-read with a byte arriving in the same cycle as deselect.
    base = weCount;
    sendHeader(8'h66, 16'h1000, 16'h0009);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    txBase = txCount;
    @(negedge clock);
    rxDv = 1'b1; rxByte = 8'h00; spiCsN = 1'b1;
    @(negedge clock);
    rxDv = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("abort_cs", {31'd0, memCs}, 32'd0);
    checkOutput("abort_status", {24'd0, status}, 32'hA5);
    checkOutput("abort_halt", {31'd0, halt}, 32'd1);
    checkOutput("abort_no_tx", txCount - txBase, 32'd0);
    spiCsN = 1'b0;
    repeat (2) @(negedge clock);
    applyStimulus(8'h33);
    checkOutput("abort_status_rd", {24'd0, lastTx}, 32'hA5);
    applyStimulus(8'h55);
    checkOutput("resume_halt", {31'd0, halt}, 32'd0);
    applyStimulus(8'h99);
    checkOutput("resume_running", {24'd0, lastTx}, 32'hEE);

    checkOutput("we_without_cs", weBad, 32'd0);
    checkOutput("no_stray_writes", weCount - base, 32'd0);
    checkOutput("reply_latency", {31'd0, maxDelay <= LAT + 2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
